// File: rtl/debug_uart_rx.sv
// Debug UART receiver (8N1, LSB first, idle high) with pop handshake and sticky error flags.
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register is used.
module debug_uart_rx #(
    parameter int CLK_HZ   = 14_000_000,
    parameter int BIT_RATE = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_pop,
    input  logic       err_clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int CNT_W = $clog2(CPB) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

    logic [1:0]       sync_q;
    logic             rxd_s;
    logic             rxd_prev;
    logic [1:0]       primed;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             push;

    assign rxd_s = sync_q[1];

    // The synchronizer resets high, so rxd_s is not a real line sample until two
    // edges after reset; rxd_prev stays low until then so a held-low line cannot
    // masquerade as a 1 -> 0 start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            primed   <= 2'b00;
            rxd_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the flop chain shift by exactly one stage per edge.
            sync_q <= {sync_q[0], uart_rxd};
            primed <= {primed[0], 1'b1};
            if (primed[1]) rxd_prev <= rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            push         <= 1'b0;
            rx_busy      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            push <= 1'b0;
            if (err_clear) rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rxd_prev && !rxd_s) begin
                        state   <= ST_START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= ST_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            push    <= 1'b1;
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // shift holds the completed byte while push is high; the next shift is many cycles away.
`ifdef UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic       pop;
    logic       do_push;

    assign pop      = rx_pop && (count != 3'd0);
    assign do_push  = push && ((count != 3'd4) || pop);
    assign rx_valid = (count != 3'd0);
    // NOTE: mem has no reset; rx_data is forced to zero while empty so stale or unknown entries never show.
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            rx_overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (err_clear) rx_overrun <= 1'b0;
            if (push && !do_push) rx_overrun <= 1'b1;
        end
    end
`else
    logic pop;

    assign pop = rx_pop && rx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (err_clear) rx_overrun <= 1'b0;
            if (push) begin
                if (!rx_valid || pop) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx: directed corner cases plus random frames against a queue model.
module tb_debug_uart_rx;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int BIT_CYC = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       rx_pop;
    logic       err_clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    debug_uart_rx #(.CLK_HZ(14_000_000), .BIT_RATE(1_000_000)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .rx_pop      (rx_pop),
        .err_clear   (err_clear),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) tick();
    endtask

    // Step j drives the value sampled at edge T+j, T being the edge that first sees the start bit.
    // The stop bit is sampled at T+135 and the byte appears after edge T+136.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit pop_at_push,
                              input bit clr_at_stop, input bit chk_push);
        for (int j = 0; j < 10 * BIT_CYC; j++) begin
            if (j < BIT_CYC) uart_rxd = 1'b0;
            else if (j < 9 * BIT_CYC) uart_rxd = b[j / BIT_CYC - 1];
            else uart_rxd = stop_bit;
            rx_pop    = pop_at_push && (j == 136);
            err_clear = clr_at_stop && (j == 135);
            tick();
            if (chk_push && j == 135) check("valid_before_push", rx_valid, 1'b0);
            if (chk_push && j == 136) begin
                check("valid_at_push", rx_valid, 1'b1);
                check("data_at_push", rx_data, b);
            end
            if (clr_at_stop && j == 135) check("set_beats_clear", rx_frame_err, 1'b1);
        end
        rx_pop    = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, rx_valid, 1'b1);
        check({tag, "_data"}, rx_data, exp);
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        logic [2:0] partial;
        bit         ovr_exp;
        int         npop;

        rst = 1'b1; uart_rxd = 1'b1; rx_pop = 1'b0; err_clear = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {rx_valid, rx_busy, rx_overrun, rx_frame_err}, 4'b0000);
        check("reset_data", rx_data, 8'h00);
        rst = 1'b0;
        idle(5);

        // single byte with push timing, then pop
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2 * BIT_CYC);
        check("a5_busy", rx_busy, 1'b0);
        check("a5_data", rx_data, 8'hA5);
        check("a5_flags", {rx_overrun, rx_frame_err}, 2'b00);
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        check("a5_valid_after_pop", rx_valid, 1'b0);

        // start glitch
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (2) tick();
        check("glitch_busy_mid", rx_busy, 1'b1);
        idle(20);
        check("glitch_busy", rx_busy, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_ferr", rx_frame_err, 1'b0);

        // framing error with line held low afterwards
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        repeat (40) tick();
        check("ferr_set", rx_frame_err, 1'b1);
        check("ferr_held_busy", rx_busy, 1'b1);
        idle(40);
        check("ferr_busy_after", rx_busy, 1'b0);
        check("ferr_no_byte", rx_valid, 1'b0);
        pulse_clear();
        check("ferr_cleared", rx_frame_err, 1'b0);
        idle(30);
        check("ferr_single_event", rx_frame_err, 1'b0);

        // err_clear coincident with framing error
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(30);
        check("coincide_ferr", rx_frame_err, 1'b1);
        check("coincide_no_byte", rx_valid, 1'b0);
        pulse_clear();
        check("coincide_cleared", rx_frame_err, 1'b0);

        // overrun
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i == DEPTH + 1) check("ovr_before", rx_overrun, 1'b0);
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            idle(2 * BIT_CYC);
        end
        check("ovr_set", rx_overrun, 1'b1);
        for (int i = 1; i <= DEPTH; i++) pop_expect("ovr_pop", 8'(i));
        check("ovr_empty", rx_valid, 1'b0);
        pulse_clear();
        check("ovr_cleared", rx_overrun, 1'b0);

        // pop in the exact push cycle while full
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            idle(2 * BIT_CYC);
        end
        send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2 * BIT_CYC);
        check("poppush_no_ovr", rx_overrun, 1'b0);
        for (int i = 1; i < DEPTH; i++) pop_expect("poppush_old", 8'h10 + 8'(i));
        pop_expect("poppush_new", 8'h77);
        check("poppush_empty", rx_valid, 1'b0);

        // random frames against a queue model
        ovr_exp = 1'b0;
        for (int f = 0; f < 16; f++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0, 1'b0);
            if (q.size() < DEPTH) q.push_back(b);
            else ovr_exp = 1'b1;
            idle($urandom_range(2 * BIT_CYC, 4 * BIT_CYC));
            npop = $urandom_range(0, 1);
            for (int k = 0; k < npop; k++) begin
                if (q.size() > 0) begin
                    pop_expect("rand_pop", q.pop_front());
                end else begin
                    check("rand_empty", rx_valid, 1'b0);
                    rx_pop = 1'b1;
                    tick();
                    rx_pop = 1'b0;
                end
            end
        end
        check("rand_overrun", rx_overrun, 32'(ovr_exp));
        check("rand_busy", rx_busy, 1'b0);

        // reset in DATA after three bits, line held low through release
        partial = 3'b101;
        for (int j = 0; j < 4 * BIT_CYC; j++) begin
            uart_rxd = (j < BIT_CYC) ? 1'b0 : partial[j / BIT_CYC - 1];
            tick();
        end
        check("pre_reset_busy", rx_busy, 1'b1);
        uart_rxd = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        check("midreset_outputs", {rx_valid, rx_busy, rx_overrun, rx_frame_err}, 4'b0000);
        check("midreset_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (30) tick();
        check("held_low_busy", rx_busy, 1'b0);
        check("held_low_flags", {rx_valid, rx_frame_err}, 2'b00);
        idle(30);
        check("held_low_after", {rx_valid, rx_busy, rx_frame_err}, 3'b000);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2 * BIT_CYC);
        check("post_reset_flags", {rx_overrun, rx_frame_err}, 2'b00);
        pop_expect("post_reset", 8'h5A);
        check("post_reset_empty", rx_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
